decode_ctrl_pipe: RTL and testbench

ID-stage controller for the 5-stage pipeline. Decodes the IF/ID instruction word and drives `id_imm_sel` to the immediate sign-extender. It registers the decoded control bundle into the ID/EX stage with stall and flush handling, and detects load-use hazards, stalling IF/ID and inserting a bubble.

---
 rtl/decode_ctrl_pipe_if.sv | 43 ++++
 rtl/decode_ctrl_pipe.sv | 159 +++++++++++++++
 tb/tb_decode_ctrl_pipe.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/decode_ctrl_pipe_if.sv
// decode_ctrl_pipe_if
//   Bundles the IF/ID -> ID/EX control signals of the decode stage.
//   master : upstream pipeline / bench (drives instruction, valid, flush)
//   slave  : decode_ctrl_pipe (drives imm select, stalls, ID/EX bundle)
//   Signals:
//     id_instr, id_valid, flush_e          -> into decode
//     id_imm_sel, stall_f, stall_d, flush_d <- combinational from decode
//     ex_valid .. ex_illegal, ex_rd         <- registered ID/EX contents
interface decode_ctrl_pipe_if #(
  parameter int unsigned REG_AW = 5
);
  logic [31:0]       id_instr;
  logic              id_valid;
  logic              flush_e;
  logic [2:0]        id_imm_sel;
  logic              stall_f;
  logic              stall_d;
  logic              flush_d;
  logic              ex_valid;
  logic              ex_reg_write;
  logic              ex_mem_read;
  logic              ex_mem_write;
  logic              ex_branch;
  logic              ex_jump;
  logic              ex_alu_src_b;
  logic [1:0]        ex_result_src;
  logic [REG_AW-1:0] ex_rd;
  logic              ex_illegal;

  modport master (
    output id_instr, id_valid, flush_e,
    input  id_imm_sel, stall_f, stall_d, flush_d,
    input  ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_branch,
    input  ex_jump, ex_alu_src_b, ex_result_src, ex_rd, ex_illegal
  );

  modport slave (
    input  id_instr, id_valid, flush_e,
    output id_imm_sel, stall_f, stall_d, flush_d,
    output ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_branch,
    output ex_jump, ex_alu_src_b, ex_result_src, ex_rd, ex_illegal
  );
endinterface

// File: rtl/decode_ctrl_pipe.sv
// decode_ctrl_pipe
//   ID-stage controller: decodes the IF/ID opcode, drives the immediate
//   select to the sign-extender, registers the control bundle into ID/EX
//   and detects load-use hazards (stall IF/ID + PC, insert bubble).
//   Ports:
//     clk   : rising-edge clock
//     rst_n : asynchronous active-low reset (clears ID/EX)
//     bus   : decode_ctrl_pipe_if.slave (instruction in, stalls/flush and
//             ID/EX control bundle out)
module decode_ctrl_pipe #(
  parameter int unsigned REG_AW    = 5,
  parameter bit          HAZARD_EN = 1'b1,
  parameter logic [2:0]  NOP_SEL   = 3'b111
) (
  input logic               clk,
  input logic               rst_n,
  decode_ctrl_pipe_if.slave bus
);

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_R      = 7'b0110011;

  typedef struct packed {
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       branch;
    logic       jump;
    logic       alu_src_b;
    logic [1:0] result_src;
    logic       illegal;
  } ctrl_t;

  ctrl_t             dec;
  logic [2:0]        imm_sel;
  logic              use_rs1;
  logic              use_rs2;
  logic [REG_AW-1:0] rs1;
  logic [REG_AW-1:0] rs2;
  logic [REG_AW-1:0] rd;

  ctrl_t             ex_ctrl_q, ex_ctrl_d;
  logic              ex_valid_q, ex_valid_d;
  logic [REG_AW-1:0] ex_rd_q, ex_rd_d;

  logic              load_use;
  logic              bubble;
  logic              unused_instr_bits;

  assign rs1 = bus.id_instr[15 +: REG_AW];
  assign rs2 = bus.id_instr[20 +: REG_AW];
  assign rd  = bus.id_instr[7  +: REG_AW];
  assign unused_instr_bits = ^{bus.id_instr[31:25], bus.id_instr[14:12]};

  always_comb begin
    dec     = '0;
    imm_sel = NOP_SEL;
    use_rs1 = 1'b0;
    use_rs2 = 1'b0;
    unique case (bus.id_instr[6:0])
      OP_LOAD: begin
        imm_sel = 3'b000; use_rs1 = 1'b1;
        dec.reg_write = 1'b1; dec.mem_read = 1'b1; dec.alu_src_b = 1'b1;
        dec.result_src = 2'b01;
      end
      OP_IMM: begin
        imm_sel = 3'b000; use_rs1 = 1'b1;
        dec.reg_write = 1'b1; dec.alu_src_b = 1'b1;
      end
      OP_JALR: begin
        imm_sel = 3'b000; use_rs1 = 1'b1;
        dec.reg_write = 1'b1; dec.jump = 1'b1; dec.alu_src_b = 1'b1;
        dec.result_src = 2'b10;
      end
      OP_STORE: begin
        imm_sel = 3'b001; use_rs1 = 1'b1; use_rs2 = 1'b1;
        dec.mem_write = 1'b1; dec.alu_src_b = 1'b1;
      end
      OP_BRANCH: begin
        imm_sel = 3'b010; use_rs1 = 1'b1; use_rs2 = 1'b1;
        dec.branch = 1'b1;
      end
      OP_JAL: begin
        imm_sel = 3'b011;
        dec.reg_write = 1'b1; dec.jump = 1'b1; dec.result_src = 2'b10;
      end
      OP_LUI, OP_AUIPC: begin
        imm_sel = 3'b100;
        dec.reg_write = 1'b1; dec.alu_src_b = 1'b1;
      end
      OP_R: begin
        use_rs1 = 1'b1; use_rs2 = 1'b1;
        dec.reg_write = 1'b1;
      end
      default: dec.illegal = 1'b1;
    endcase
  end

  // Only a load already in EX can create a hazard; x0 is never a real producer.
  always_comb begin
    load_use = 1'b0;
    if (HAZARD_EN) begin
      load_use = ex_valid_q && ex_ctrl_q.mem_read && (ex_rd_q != '0) &&
                 bus.id_valid &&
                 ((use_rs1 && (rs1 == ex_rd_q)) || (use_rs2 && (rs2 == ex_rd_q)));
    end
  end

  // A flush kills the stalled instruction anyway, so it overrides the stall.
  assign bubble = load_use || bus.flush_e;

  always_comb begin
    ex_ctrl_d  = '0;
    ex_valid_d = 1'b0;
    ex_rd_d    = '0;
    if (!bubble) begin
      ex_valid_d = bus.id_valid;
      if (bus.id_valid) begin
        ex_ctrl_d = dec;
      end
      ex_rd_d = (dec.mem_write || dec.branch) ? '0 : rd;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_ctrl_q  <= '0;
      ex_valid_q <= 1'b0;
      ex_rd_q    <= '0;
    end else begin
      ex_ctrl_q  <= ex_ctrl_d;
      ex_valid_q <= ex_valid_d;
      ex_rd_q    <= ex_rd_d;
    end
  end

  assign bus.id_imm_sel    = imm_sel;
  assign bus.stall_f       = load_use && !bus.flush_e;
  assign bus.stall_d       = load_use && !bus.flush_e;
  assign bus.flush_d       = bus.flush_e;
  assign bus.ex_valid      = ex_valid_q;
  assign bus.ex_reg_write  = ex_ctrl_q.reg_write;
  assign bus.ex_mem_read   = ex_ctrl_q.mem_read;
  assign bus.ex_mem_write  = ex_ctrl_q.mem_write;
  assign bus.ex_branch     = ex_ctrl_q.branch;
  assign bus.ex_jump       = ex_ctrl_q.jump;
  assign bus.ex_alu_src_b  = ex_ctrl_q.alu_src_b;
  assign bus.ex_result_src = ex_ctrl_q.result_src;
  assign bus.ex_rd         = ex_rd_q;
  assign bus.ex_illegal    = ex_ctrl_q.illegal;

endmodule

// File: tb/tb_decode_ctrl_pipe.sv
// tb_decode_ctrl_pipe
//   Bench for decode_ctrl_pipe: a table-driven reference model of the
//   ID/EX register plus directed scenarios with literal expectations,
//   followed by randomized instruction streams.
module tb_decode_ctrl_pipe;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  decode_ctrl_pipe_if #(.REG_AW(5)) bus ();

  decode_ctrl_pipe #(.REG_AW(5), .HAZARD_EN(1'b1), .NOP_SEL(3'b111)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h @%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [2:0] imm;
    logic       rw, mr, mw, br, j, asb;
    logic [1:0] rs;
    logic       ill, u1, u2, no_rd;
  } dec_t;

  typedef struct packed {
    logic       v, rw, mr, mw, br, j, asb;
    logic [1:0] rs;
    logic       ill;
    logic [4:0] rd;
  } ex_t;

  // Opcode table: imm, rw mr mw br j asb, result, ill, uses rs1/rs2, rd dropped
  function automatic dec_t ref_dec(input logic [6:0] op);
    case (op)
      7'b0000011: return '{3'd0, 1,1,0,0,0,1, 2'b01, 0, 1,0, 0};
      7'b0010011: return '{3'd0, 1,0,0,0,0,1, 2'b00, 0, 1,0, 0};
      7'b1100111: return '{3'd0, 1,0,0,0,1,1, 2'b10, 0, 1,0, 0};
      7'b0100011: return '{3'd1, 0,0,1,0,0,1, 2'b00, 0, 1,1, 1};
      7'b1100011: return '{3'd2, 0,0,0,1,0,0, 2'b00, 0, 1,1, 1};
      7'b1101111: return '{3'd3, 1,0,0,0,1,0, 2'b10, 0, 0,0, 0};
      7'b0110111,
      7'b0010111: return '{3'd4, 1,0,0,0,0,1, 2'b00, 0, 0,0, 0};
      7'b0110011: return '{3'd7, 1,0,0,0,0,0, 2'b00, 0, 1,1, 0};
      default:    return '{3'd7, 0,0,0,0,0,0, 2'b00, 1, 0,0, 0};
    endcase
  endfunction

  ex_t m;

  function automatic logic model_hz(input ex_t s, input logic [31:0] ins, input logic vld);
    dec_t d;
    logic [4:0] r1, r2;
    d  = ref_dec(ins[6:0]);
    r1 = ins[19:15];
    r2 = ins[24:20];
    return s.v && s.mr && (s.rd != 5'd0) && vld &&
           ((d.u1 && r1 == s.rd) || (d.u2 && r2 == s.rd));
  endfunction

  function automatic ex_t model_next(input ex_t s, input logic [31:0] ins,
                                     input logic vld, input logic fl);
    dec_t d;
    ex_t  n;
    d = ref_dec(ins[6:0]);
    n = '0;
    if (!(fl || model_hz(s, ins, vld))) begin
      n.v = vld;
      if (vld) {n.rw, n.mr, n.mw, n.br, n.j, n.asb, n.rs, n.ill} =
               {d.rw, d.mr, d.mw, d.br, d.j, d.asb, d.rs, d.ill};
      n.rd = d.no_rd ? 5'd0 : ins[11:7];
    end
    return n;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m <= '0;
    else        m <= model_next(m, bus.id_instr, bus.id_valid, bus.flush_e);
  end

  // Compare every cycle, away from the active edge.
  always @(negedge clk) begin
    logic hz;
    ex_t  act;
    hz  = model_hz(m, bus.id_instr, bus.id_valid) && !bus.flush_e;
    act = {bus.ex_valid, bus.ex_reg_write, bus.ex_mem_read, bus.ex_mem_write,
           bus.ex_branch, bus.ex_jump, bus.ex_alu_src_b, bus.ex_result_src,
           bus.ex_illegal, bus.ex_rd};
    check("mdl_imm_sel", {29'd0, bus.id_imm_sel}, {29'd0, ref_dec(bus.id_instr[6:0]).imm});
    check("mdl_stall_f", {31'd0, bus.stall_f}, {31'd0, hz});
    check("mdl_stall_d", {31'd0, bus.stall_d}, {31'd0, hz});
    check("mdl_flush_d", {31'd0, bus.flush_d}, {31'd0, bus.flush_e});
    check("mdl_ex_bundle", {17'd0, act}, {17'd0, m});
  end

  // ---------------- stimulus ----------------
  localparam logic [6:0] LD = 7'b0000011, ST = 7'b0100011, BR = 7'b1100011,
                         JL = 7'b1101111, LU = 7'b0110111, RR = 7'b0110011,
                         OI = 7'b0010011, JR = 7'b1100111, AU = 7'b0010111;

  function automatic logic [31:0] mk(input logic [6:0] op, input logic [4:0] rd,
                                     input logic [4:0] r1, input logic [4:0] r2);
    return {7'd0, r2, r1, 3'd0, rd, op};
  endfunction

  task automatic step(input logic [31:0] ins, input logic vld, input logic fl);
    @(posedge clk);
    #1;
    bus.id_instr = ins;
    bus.id_valid = vld;
    bus.flush_e  = fl;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [6:0] sweep_op [6];
    logic [2:0] sweep_exp [6];
    logic [6:0] rnd_ops [11];
    logic [31:0] r;

    sweep_op  = '{LD, ST, BR, JL, LU, RR};
    sweep_exp = '{3'b000, 3'b001, 3'b010, 3'b011, 3'b100, 3'b111};
    rnd_ops   = '{LD, LD, OI, JR, ST, BR, JL, LU, AU, RR, 7'b1111111};

    rst_n = 1'b0;
    bus.id_instr = '0;
    bus.id_valid = 1'b0;
    bus.flush_e  = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    check("reset_ex_valid", {31'd0, bus.ex_valid}, 32'd0);
    check("reset_stall_f", {31'd0, bus.stall_f}, 32'd0);

    // immediate select sweep, same cycle
    for (int i = 0; i < 6; i++) begin
      step(mk(sweep_op[i], 5'd1, 5'd2, 5'd3), 1'b0, 1'b0);
      #1;
      check($sformatf("imm_sweep_%0d", i), {29'd0, bus.id_imm_sel}, {29'd0, sweep_exp[i]});
    end

    // load-use: lw x5,0(x1); add x6,x5,x2
    step(mk(LD, 5, 1, 0), 1'b1, 1'b0);
    step(mk(RR, 6, 5, 2), 1'b1, 1'b0);
    @(negedge clk);
    check("lu_stall_f", {31'd0, bus.stall_f}, 32'd1);
    check("lu_stall_d", {31'd0, bus.stall_d}, 32'd1);
    step(mk(RR, 6, 5, 2), 1'b1, 1'b0);
    @(negedge clk);
    check("lu_bubble_valid", {31'd0, bus.ex_valid}, 32'd0);
    check("lu_stall_once", {31'd0, bus.stall_f}, 32'd0);
    step(32'd0, 1'b0, 1'b0);
    @(negedge clk);
    check("lu_add_regwrite", {31'd0, bus.ex_reg_write}, 32'd1);
    check("lu_add_rd", {27'd0, bus.ex_rd}, 32'd6);

    // no false hazards
    step(mk(LD, 0, 1, 0), 1'b1, 1'b0);
    step(mk(RR, 1, 0, 0), 1'b1, 1'b0);
    @(negedge clk);
    check("nohz_x0", {31'd0, bus.stall_f}, 32'd0);
    step(mk(LD, 5, 1, 0), 1'b1, 1'b0);
    step(mk(LU, 5, 5, 5), 1'b1, 1'b0);
    @(negedge clk);
    check("nohz_lui", {31'd0, bus.stall_f}, 32'd0);
    step(mk(LD, 5, 1, 0), 1'b1, 1'b0);
    step(mk(JL, 1, 5, 5), 1'b1, 1'b0);
    @(negedge clk);
    check("nohz_jal", {31'd0, bus.stall_f}, 32'd0);

    // flush beats hazard
    step(mk(LD, 5, 1, 0), 1'b1, 1'b0);
    step(mk(RR, 6, 5, 2), 1'b1, 1'b1);
    @(negedge clk);
    check("fl_stall_f", {31'd0, bus.stall_f}, 32'd0);
    check("fl_flush_d", {31'd0, bus.flush_d}, 32'd1);
    step(32'd0, 1'b0, 1'b0);
    @(negedge clk);
    check("fl_ex_valid", {31'd0, bus.ex_valid}, 32'd0);

    // illegal / invalid
    step(32'h0000_007F, 1'b1, 1'b0);
    step(32'h0000_007F, 1'b0, 1'b0);
    @(negedge clk);
    check("ill_flag", {31'd0, bus.ex_illegal}, 32'd1);
    check("ill_enables", {27'd0, bus.ex_reg_write, bus.ex_mem_read, bus.ex_mem_write,
                          bus.ex_branch, bus.ex_jump}, 32'd0);
    step(32'd0, 1'b0, 1'b0);
    @(negedge clk);
    check("ill_invalid_flag", {31'd0, bus.ex_illegal}, 32'd0);
    check("ill_invalid_valid", {31'd0, bus.ex_valid}, 32'd0);

    // reset mid-stream with a load in ID/EX
    step(mk(LD, 5, 1, 0), 1'b1, 1'b0);
    step(mk(RR, 6, 5, 2), 1'b1, 1'b0);
    check("rst_pre_memread", {31'd0, bus.ex_mem_read}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("rst_async_memread", {31'd0, bus.ex_mem_read}, 32'd0);
    check("rst_async_valid", {31'd0, bus.ex_valid}, 32'd0);
    check("rst_async_stall", {31'd0, bus.stall_f}, 32'd0);
    #2 rst_n = 1'b1;

    // randomized stream, small register range to provoke hazards
    for (int i = 0; i < 2000; i++) begin
      r = $urandom();
      r[6:0]   = rnd_ops[$urandom_range(0, 10)];
      if ($urandom_range(0, 15) == 0) r[6:0] = 7'($urandom());
      r[11:7]  = 5'($urandom_range(0, 3));
      r[19:15] = 5'($urandom_range(0, 3));
      r[24:20] = 5'($urandom_range(0, 3));
      step(r, ($urandom_range(0, 9) < 8), ($urandom_range(0, 9) == 0));
    end
    step(32'd0, 1'b0, 1'b0);
    @(negedge clk);
    @(posedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
